// File: rtl/fabric_config_loader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fabric_config_loader
//
// Purpose:
//    Walks the fabric configuration image (switch-box configure words and
//    LUT mem words) out of the config ROM and writes it, word by word, into
//    the fabric config registers over a simple write bus. The fabric is held
//    disabled until the whole image has been written, then enabled.
//
// Ports:
//    clock      system clock, everything happens on the rising edge
//    reset      synchronous, active-high reset (priority over all inputs)
//    start      single-cycle load request, ignored while busy
//    rom_en     ROM read enable, data returns on rom_data the cycle after
//    rom_addr   ROM word address
//    rom_data   ROM read data
//    cfg_we     config write strobe
//    cfg_addr   config word index, decoded downstream to the sb_*/lt_* target
//    cfg_data   config write data
//    cfg_ready  target accepts the write in this cycle
//    busy       load in progress
//    done       image loaded (level)
//    fabric_en  fabric operational enable, only ever high in DONE
//    cfg_err    checksum mismatch (only with CFG_CHECKSUM_EN)
//
// Build option:
//    CFG_CHECKSUM_EN  when defined, a checksum word stored at ROM address
//                     NUM_WORDS (XOR of all image words) is fetched after the
//                     last write and compared against a running XOR of the
//                     words actually written. A mismatch raises cfg_err and
//                     keeps fabric_en low.
// ---------------------------------------------------------------------------
module fabric_config_loader #(
   parameter int NUM_WORDS = 33,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              cfg_we,
   output logic [ADDR_W-1:0] cfg_addr,
   output logic [DATA_W-1:0] cfg_data,
   input  logic              cfg_ready,
   output logic              busy,
   output logic              done,
`ifdef CFG_CHECKSUM_EN
   output logic              fabric_en,
   output logic              cfg_err
`else
   output logic              fabric_en
`endif
);

   // Index of the final image word; the write of this word ends the sequence.
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

`ifdef CFG_CHECKSUM_EN
   // The checksum sits immediately after the image in the ROM.
   localparam logic [ADDR_W-1:0] CHECK_ADDR = ADDR_W'(NUM_WORDS);
`endif

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      WRITE,
`ifdef CFG_CHECKSUM_EN
      DONE,
      CHECK_FETCH,
      CHECK_LATCH,
      CHECK
`else
      DONE
`endif
   } stateT;

   stateT             state;
   stateT             nextState;
   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] dataReg;
   logic              loadStart;
   logic              writeAck;
   logic              lastWord;

`ifdef CFG_CHECKSUM_EN
   logic [DATA_W-1:0] xorAcc;
   logic              cfgErr;
`endif

   // A write retires only on an edge where the strobe is up and the target
   // says ready; the last-word flag decides whether we loop or finish.
   assign writeAck = (state == WRITE) && cfg_ready;
   assign lastWord = (idx == LAST_IDX);

   // State register. Reset is synchronous and wins over everything, so a
   // reset in the middle of a load drops straight back to IDLE and leaves
   // whatever was already written sitting in the targets.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and output decode. All outputs are pure functions of the
   // current state (plus idx/data register), so the write bus naturally
   // holds cfg_we/cfg_addr/cfg_data steady for as long as the target stalls
   // us in WRITE. start is only looked at in IDLE and DONE, which is what
   // makes it ignored (not queued) while a load is running.
   always_comb begin
      nextState = state;
      rom_en    = 1'b0;
      rom_addr  = '0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_data  = '0;
      busy      = 1'b1;
      done      = 1'b0;
      fabric_en = 1'b0;
      loadStart = 1'b0;

      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               nextState = FETCH;
               loadStart = 1'b1;
            end
         end

         FETCH: begin
            rom_en    = 1'b1;
            rom_addr  = idx;
            nextState = LATCH;
         end

         LATCH: begin
            nextState = WRITE;
         end

         WRITE: begin
            cfg_we   = 1'b1;
            cfg_addr = idx;
            cfg_data = dataReg;
            if (cfg_ready) begin
               if (lastWord) begin
`ifdef CFG_CHECKSUM_EN
                  nextState = CHECK_FETCH;
`else
                  nextState = DONE;
`endif
               end else begin
                  nextState = FETCH;
               end
            end
         end

`ifdef CFG_CHECKSUM_EN
         CHECK_FETCH: begin
            rom_en    = 1'b1;
            rom_addr  = CHECK_ADDR;
            nextState = CHECK_LATCH;
         end

         CHECK_LATCH: begin
            nextState = CHECK;
         end

         CHECK: begin
            nextState = DONE;
         end
`endif

         DONE: begin
            busy = 1'b0;
            done = 1'b1;
`ifdef CFG_CHECKSUM_EN
            fabric_en = ~cfgErr;
`else
            fabric_en = 1'b1;
`endif
            if (start) begin
               nextState = FETCH;
               loadStart = 1'b1;
            end
         end

         default: begin
            busy      = 1'b0;
            nextState = IDLE;
         end
      endcase
   end

   // Word index and data register. idx restarts at zero on every accepted
   // start and advances only when a write retires, and it is never bumped
   // past the last word, so the write bus can never show an out-of-image
   // index. The data register grabs rom_data in the LATCH cycle, which is
   // the cycle the ROM presents the word fetched in FETCH.
   always_ff @(posedge clock) begin
      if (reset) begin
         idx     <= '0;
         dataReg <= '0;
      end else begin
         if (loadStart) begin
            idx <= '0;
         end else if (writeAck && !lastWord) begin
            idx <= idx + ADDR_W'(1);
         end
`ifdef CFG_CHECKSUM_EN
         if ((state == LATCH) || (state == CHECK_LATCH)) begin
            dataReg <= rom_data;
         end
`else
         if (state == LATCH) begin
            dataReg <= rom_data;
         end
`endif
      end
   end

`ifdef CFG_CHECKSUM_EN
   // Running checksum over exactly the words that went out on the write bus,
   // and the sticky error flag. Both clear on an accepted start so a good
   // reload recovers the fabric after a bad image. In CHECK the data
   // register holds the checksum word from the ROM.
   always_ff @(posedge clock) begin
      if (reset) begin
         xorAcc <= '0;
         cfgErr <= 1'b0;
      end else begin
         if (loadStart) begin
            xorAcc <= '0;
            cfgErr <= 1'b0;
         end else begin
            if (writeAck) begin
               xorAcc <= xorAcc ^ dataReg;
            end
            if (state == CHECK) begin
               cfgErr <= (xorAcc != dataReg);
            end
         end
      end
   end

   assign cfg_err = cfgErr;
`endif

endmodule

// File: tb/tb_fabric_config_loader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_fabric_config_loader
//
// Directed bench for fabric_config_loader. A behavioural ROM returns word
// i = 32'hA500_0000 + i one cycle after rom_en, with the XOR checksum of the
// image at address 33. Inputs change 1ns after the rising edge; outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fabric_config_loader;

   localparam int NW = 33;
   localparam int DW = 32;
   localparam int AW = 6;
`ifdef CFG_CHECKSUM_EN
   localparam int EXTRA = 3;
`else
   localparam int EXTRA = 0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          rom_en;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   logic          cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [DW-1:0] cfg_data;
   logic          cfg_ready;
   logic          busy;
   logic          done;
   logic          fabric_en;
`ifdef CFG_CHECKSUM_EN
   logic          cfg_err;
`endif

   logic [DW-1:0] romMem [0:63];
   logic [DW-1:0] romQ = '0;
   int            edgeCnt = 0;
   int            vectors = 0;
   int            miscompares = 0;

   fabric_config_loader #(
      .NUM_WORDS(NW),
      .DATA_W(DW),
      .ADDR_W(AW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .rom_en(rom_en),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .cfg_we(cfg_we),
      .cfg_addr(cfg_addr),
      .cfg_data(cfg_data),
      .cfg_ready(cfg_ready),
      .busy(busy),
      .done(done),
`ifdef CFG_CHECKSUM_EN
      .fabric_en(fabric_en),
      .cfg_err(cfg_err)
`else
      .fabric_en(fabric_en)
`endif
   );

   // Free-running clock, 10ns period.
   initial begin
      forever #5 clock = ~clock;
   end

   // Edge counter used for latency measurement.
   always @(posedge clock) begin
      edgeCnt = edgeCnt + 1;
   end

   // Synchronous ROM: one cycle read latency.
   always @(posedge clock) begin
      if (rom_en) romQ <= romMem[rom_addr];
   end
   assign rom_data = romQ;

   // Hard stop in case something wedges outside the bounded loops.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Pulse start, then run cycle by cycle until done or budget expires,
   // applying optional back-pressure at one address and an optional extra
   // start pulse while busy. Reports what was observed on the write bus.
   task automatic runLoad(input int stallAddr, input int stallCycles, input int pokeAddr,
                          output int latency, output int nWrites, output int seqBad,
                          output int unstable, output int fabBad,
                          output logic firstDone, output logic firstFab);
      int            startEdge;
      int            stallLeft;
      bit            poked;
      bit            prevStalled;
      bit            first;
      logic [AW-1:0] prevAddr;
      logic [DW-1:0] prevData;
      latency     = -1;
      nWrites     = 0;
      seqBad      = 0;
      unstable    = 0;
      fabBad      = 0;
      firstDone   = 1'b1;
      firstFab    = 1'b1;
      stallLeft   = stallCycles;
      poked       = 0;
      prevStalled = 0;
      first       = 1;
      prevAddr    = '0;
      prevData    = '0;
      cfg_ready   = 1'b1;
      start       = 1'b1;
      @(posedge clock);
      #1;
      startEdge = edgeCnt;
      start = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if (stallAddr >= 0 && cfg_we === 1'b1 && int'(cfg_addr) == stallAddr && stallLeft > 0) begin
            cfg_ready = 1'b0;
            stallLeft--;
         end else begin
            cfg_ready = 1'b1;
         end
         if (pokeAddr >= 0 && !poked && cfg_we === 1'b1 && int'(cfg_addr) == pokeAddr) begin
            start = 1'b1;
            poked = 1;
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
         if (first) begin
            firstDone = done;
            firstFab  = fabric_en;
            first     = 0;
         end
         if (prevStalled && (cfg_we !== 1'b1 || cfg_addr !== prevAddr || cfg_data !== prevData))
            unstable++;
         prevStalled = (cfg_we === 1'b1 && cfg_ready === 1'b0);
         prevAddr    = cfg_addr;
         prevData    = cfg_data;
         if (cfg_we === 1'b1 && cfg_ready === 1'b1) begin
            if (nWrites > 63 || int'(cfg_addr) != nWrites || cfg_data !== romMem[nWrites])
               seqBad++;
            nWrites++;
         end
         if (fabric_en !== 1'b0 && done !== 1'b1) fabBad++;
         if (done === 1'b1) begin
            latency = edgeCnt - startEdge;
            break;
         end
         @(posedge clock);
         #1;
      end
      start     = 1'b0;
      cfg_ready = 1'b1;
   endtask

   // Reset together with start: reset wins, everything idle and zero.
   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      cfg_ready = 1'b1;
      @(posedge clock);
      #1;
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
      vectors++;
      if (fabric_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fabric_en got %b want 0", fabric_en); end
      vectors++;
      if (cfg_we !== 1'b0 || rom_en !== 1'b0) begin
         miscompares++; $display("[TB] FAIL reset_strobes got we=%b rom_en=%b want 0/0", cfg_we, rom_en);
      end
`ifdef CFG_CHECKSUM_EN
      vectors++;
      if (cfg_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cfg_err got %b want 0", cfg_err); end
`endif
      start = 1'b0;
      reset = 1'b0;
      @(posedge clock);
      #1;
      vectors++;
      if (busy !== 1'b0 || rom_en !== 1'b0) begin
         miscompares++; $display("[TB] FAIL reset_stays_idle got busy=%b rom_en=%b want 0/0", busy, rom_en);
      end
   endtask

   // Plain load with cfg_ready held high.
   task automatic test_load();
      int lat, nw, sb, us, fb;
      logic fd, ff;
      runLoad(-1, 0, -1, lat, nw, sb, us, fb, fd, ff);
      vectors++;
      if (lat != 3*NW + EXTRA) begin miscompares++; $display("[TB] FAIL load_latency got %0d want %0d", lat, 3*NW + EXTRA); end
      vectors++;
      if (nw != NW) begin miscompares++; $display("[TB] FAIL load_write_count got %0d want %0d", nw, NW); end
      vectors++;
      if (sb != 0) begin miscompares++; $display("[TB] FAIL load_sequence got %0d bad writes want 0", sb); end
      vectors++;
      if (fb != 0 || fd !== 1'b0) begin
         miscompares++; $display("[TB] FAIL load_early_enable got fabBad=%0d firstDone=%b want 0/0", fb, fd);
      end
      vectors++;
      if (done !== 1'b1 || fabric_en !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL load_final got done=%b fabric_en=%b busy=%b want 1/1/0", done, fabric_en, busy);
      end
      repeat (3) @(negedge clock);
      vectors++;
      if (done !== 1'b1 || fabric_en !== 1'b1 || cfg_we !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL load_done_level got done=%b fabric_en=%b we=%b want 1/1/0", done, fabric_en, cfg_we);
      end
`ifdef CFG_CHECKSUM_EN
      vectors++;
      if (cfg_err !== 1'b0) begin miscompares++; $display("[TB] FAIL load_cfg_err got %b want 0", cfg_err); end
`endif
   endtask

   // Five stalled cycles at address 7 (started from DONE).
   task automatic test_backpressure();
      int lat, nw, sb, us, fb;
      logic fd, ff;
      runLoad(7, 5, -1, lat, nw, sb, us, fb, fd, ff);
      vectors++;
      if (lat != 3*NW + 5 + EXTRA) begin
         miscompares++; $display("[TB] FAIL bp_latency got %0d want %0d", lat, 3*NW + 5 + EXTRA);
      end
      vectors++;
      if (us != 0) begin miscompares++; $display("[TB] FAIL bp_stable got %0d changes want 0", us); end
      vectors++;
      if (nw != NW || sb != 0) begin
         miscompares++; $display("[TB] FAIL bp_writes got count=%0d bad=%0d want %0d/0", nw, sb, NW);
      end
   endtask

   // Extra start pulse while writing word 10 must be ignored.
   task automatic test_start_while_busy();
      int lat, nw, sb, us, fb;
      logic fd, ff;
      runLoad(-1, 0, 10, lat, nw, sb, us, fb, fd, ff);
      vectors++;
      if (lat != 3*NW + EXTRA) begin miscompares++; $display("[TB] FAIL busy_start_latency got %0d want %0d", lat, 3*NW + EXTRA); end
      vectors++;
      if (nw != NW || sb != 0) begin
         miscompares++; $display("[TB] FAIL busy_start_writes got count=%0d bad=%0d want %0d/0", nw, sb, NW);
      end
   endtask

   // start while in DONE: done and fabric_en drop on that edge, full reload.
   task automatic test_restart_from_done();
      int lat, nw, sb, us, fb;
      logic fd, ff;
      vectors++;
      if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_precond got done=%b want 1", done); end
      runLoad(-1, 0, -1, lat, nw, sb, us, fb, fd, ff);
      vectors++;
      if (fd !== 1'b0 || ff !== 1'b0) begin
         miscompares++; $display("[TB] FAIL restart_drop got done=%b fabric_en=%b want 0/0", fd, ff);
      end
      vectors++;
      if (lat != 3*NW + EXTRA || nw != NW || sb != 0) begin
         miscompares++;
         $display("[TB] FAIL restart_reload got lat=%0d count=%0d bad=%0d want %0d/%0d/0", lat, nw, sb, 3*NW + EXTRA, NW);
      end
   endtask

   // One-cycle reset during word 20, then a full reload.
   task automatic test_reset_midload();
      int lat, nw, sb, us, fb;
      logic fd, ff;
      bit found;
      found = 0;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (cfg_we === 1'b1 && cfg_addr === AW'(20)) begin
            found = 1;
            break;
         end
         @(posedge clock);
         #1;
      end
      vectors++;
      if (!found) begin miscompares++; $display("[TB] FAIL midreset_reach got 0 want 1 (word 20 never seen)"); end
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      vectors++;
      if (busy !== 1'b0 || cfg_we !== 1'b0 || fabric_en !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midreset_idle got busy=%b we=%b fabric_en=%b done=%b want 0/0/0/0", busy, cfg_we, fabric_en, done);
      end
      repeat (3) @(posedge clock);
      #1;
      vectors++;
      if (busy !== 1'b0 || fabric_en !== 1'b0) begin
         miscompares++; $display("[TB] FAIL midreset_hold got busy=%b fabric_en=%b want 0/0", busy, fabric_en);
      end
      runLoad(-1, 0, -1, lat, nw, sb, us, fb, fd, ff);
      vectors++;
      if (lat != 3*NW + EXTRA || nw != NW || sb != 0) begin
         miscompares++;
         $display("[TB] FAIL midreset_reload got lat=%0d count=%0d bad=%0d want %0d/%0d/0", lat, nw, sb, 3*NW + EXTRA, NW);
      end
   endtask

`ifdef CFG_CHECKSUM_EN
   // Corrupt checksum bit 0: error flagged, done up, fabric stays off; a
   // reload with the correct checksum recovers.
   task automatic test_checksum();
      int lat, nw, sb, us, fb;
      logic fd, ff;
      romMem[NW] = romMem[NW] ^ 32'h1;
      runLoad(-1, 0, -1, lat, nw, sb, us, fb, fd, ff);
      vectors++;
      if (cfg_err !== 1'b1 || done !== 1'b1 || fabric_en !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL cks_bad got err=%b done=%b fabric_en=%b want 1/1/0", cfg_err, done, fabric_en);
      end
      vectors++;
      if (nw != NW || lat != 3*NW + 3) begin
         miscompares++; $display("[TB] FAIL cks_bad_seq got count=%0d lat=%0d want %0d/%0d", nw, lat, NW, 3*NW + 3);
      end
      romMem[NW] = romMem[NW] ^ 32'h1;
      runLoad(-1, 0, -1, lat, nw, sb, us, fb, fd, ff);
      vectors++;
      if (cfg_err !== 1'b0 || fabric_en !== 1'b1 || lat != 3*NW + 3) begin
         miscompares++;
         $display("[TB] FAIL cks_good got err=%b fabric_en=%b lat=%0d want 0/1/%0d", cfg_err, fabric_en, lat, 3*NW + 3);
      end
   endtask
`endif

   // Test sequence.
   initial begin
      logic [DW-1:0] cks;
      reset = 1'b1;
      start = 1'b0;
      cfg_ready = 1'b1;
      for (int i = 0; i < 64; i++) romMem[i] = 32'hA500_0000 + i;
      cks = '0;
      for (int i = 0; i < NW; i++) cks = cks ^ romMem[i];
      romMem[NW] = cks;

      test_reset();
      test_load();
      test_backpressure();
      test_start_while_busy();
      test_restart_from_done();
      test_reset_midload();
`ifdef CFG_CHECKSUM_EN
      test_checksum();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fabric_config_loader.md
Name: fabric_config_loader

Overview:
- Sequencer that loads the fabric configuration image (switch-box `configure` words, LUT `mem` words) from a config ROM into the fabric config registers over a simple write bus.
- Replaces hierarchical pokes with a real load sequence.
- Holds the fabric disabled until the whole image is written, then enables it.
- Sits between the config ROM and the fabric's config-write decoder.

Parameters:
- NUM_WORDS, 33, number of configuration words in the image (word index 0..NUM_WORDS-1).
- DATA_W, 32, width of one configuration word.
- ADDR_W, 6, width of ROM address and cfg_addr; must satisfy 2^ADDR_W > NUM_WORDS.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle load request.
- rom_en  out  1  ROM read enable; data valid the cycle after.
- rom_addr  out  ADDR_W  ROM word address.
- rom_data  in  DATA_W  ROM read data.
- cfg_we  out  1  config write strobe.
- cfg_addr  out  ADDR_W  config word index, decoded downstream to the sb_*/lt_* target.
- cfg_data  out  DATA_W  config write data.
- cfg_ready  in  1  target accepts the write this cycle.
- busy  out  1  load in progress.
- done  out  1  image loaded; level signal.
- fabric_en  out  1  fabric operational enable.
- cfg_err  out  1  checksum mismatch; present only with CFG_CHECKSUM_EN.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on port `reset`. Reset has priority over all other inputs.
- Reset values: all outputs 0, state IDLE, idx 0, data register 0.
- States: IDLE, FETCH, LATCH, WRITE, DONE (plus CHECK_FETCH, CHECK_LATCH, CHECK with the optional feature).
- IDLE: if start is sampled 1, go to FETCH and set idx=0.
- FETCH: rom_en=1, rom_addr=idx. Next state LATCH.
- LATCH: rom_en=0. At the closing edge, rom_data is captured into the data register. Next state WRITE.
- WRITE: cfg_we=1, cfg_addr=idx, cfg_data=data register.
  - Write completes on an edge where cfg_we and cfg_ready are both 1.
  - While cfg_ready=0, cfg_we, cfg_addr and cfg_data hold stable.
  - On completion: if idx==NUM_WORDS-1, go to DONE; otherwise idx+1 and go to FETCH.
- DONE: done=1, fabric_en=1, busy=0. If start is sampled 1, go to FETCH with idx=0. On that edge done and fabric_en drop to 0.
- busy=1 in every state other than IDLE and DONE.
- start is ignored while busy; no queueing.
- fabric_en=0 at all times except in DONE.
- Latency with cfg_ready always 1: 3 edges per word. done rises 3*NUM_WORDS edges after the edge that sampled start (99 for the default).
- Each cfg_ready=0 cycle adds exactly one edge.
- idx never exceeds NUM_WORDS-1 on the write bus. No wrap, skip or duplicate writes.
- Reset mid-load returns to IDLE immediately. Partially written config is left in the targets, and fabric_en stays 0 until a full reload completes.
- Simultaneous reset and start: reset wins, state IDLE.

Optional Feature:
- Macro: CFG_CHECKSUM_EN.
- Defined:
  - The ROM holds a checksum word at address NUM_WORDS, equal to the XOR of words 0..NUM_WORDS-1.
  - A running XOR accumulates every word written; it is cleared on start.
  - After the last write, the sequence is CHECK_FETCH (rom_en=1, rom_addr=NUM_WORDS) -> CHECK_LATCH -> CHECK -> DONE. The checksum word is never driven on the write bus.
  - In CHECK, a mismatch sets cfg_err=1, and DONE then holds fabric_en=0. done still asserts.
  - cfg_err clears on reset or on the next accepted start.
  - Nominal latency is 3*NUM_WORDS+3 edges.
- Undefined: no cfg_err port, no checksum fetch, latency 3*NUM_WORDS.

Test Plan:
- Load: ROM word i = 32'hA500_0000+i, cfg_ready=1, start pulse -> 33 writes with cfg_addr 0..32 in order and cfg_data = 32'hA500_0000+cfg_addr. done=fabric_en=1 exactly 99 edges after start; busy low afterwards.
- Back-pressure: cfg_ready=0 for 5 cycles while cfg_addr=7 -> cfg_we/addr/data stable throughout, exactly one write per address, done at edge 104.
- start pulsed again while busy at word 10 -> ignored; write sequence and done timing identical to the load scenario.
- reset asserted for one cycle during word 20 -> next cycle busy=0, cfg_we=0, fabric_en=0, done=0. A subsequent start reloads from cfg_addr 0 with full 99-edge latency.
- start in DONE -> done and fabric_en fall on that edge and the full 33-word reload repeats.
- With CFG_CHECKSUM_EN:
  - correct checksum at ROM[33] -> cfg_err=0, fabric_en=1 at edge 102, no write to cfg_addr 33.
  - checksum bit 0 flipped -> cfg_err=1, done=1, fabric_en=0.
